tx232_ser: RTL
==============

TX232_SER -- requirements
Module: tx232_ser

Interface
REQ-001 The block SHALL have no parameters; the only build-time option is the macro in Configuration.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 txck  input  1  baud clock; one bit period per txck cycle; sampled in the clk domain.
REQ-006 txpd  input  8  parallel byte from the upstream packer; valid while tnpd is high.
REQ-007 tnpd  input  1  byte-available strobe; spans several txck periods; only its rising edge is significant.
REQ-008 ovr_clr  input  1  clears the ovr flag.
REQ-009 txd  output  1  serial line; idles high.
REQ-010 busy  output  1  high while a byte is held or any frame bit is on the line.
REQ-011 ovr  output  1  sticky overrun flag.

Function
REQ-012 txck SHALL pass through a 2-stage clk register chain txck_d; the baud tick is txck_r = txck_d[0] & ~txck_d[1].
REQ-013 tnpd SHALL be registered once as tnpd_d; the capture event is tnpd & ~tnpd_d.
REQ-014 On a capture event with the hold register empty, txpd SHALL be written to the hold register and hold_full set on the same clk edge.
REQ-015 A capture event with hold_full=1 and no load on the same edge SHALL drop the new byte and set ovr=1.
REQ-016 On a capture event coinciding with a load, the old hold byte SHALL go to the shifter, the new byte SHALL be written to hold, hold_full SHALL stay 1, and ovr SHALL be unchanged.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY and STOP, and every transition SHALL occur only on a clk edge where txck_r=1.
REQ-018 IDLE: txd=1; if hold_full=1, the FSM SHALL load the shifter from hold, clear hold_full, drive txd=0 and go to START.
REQ-019 START goes to DATA, driving bit 0; DATA shifts LSB first, driving one bit per tick with a 3-bit counter from 0 to 7.
REQ-020 After bit 7, the FSM goes to PARITY (macro defined) or STOP (macro undefined); PARITY drives the even parity bit (XOR of the 8 bits), then goes to STOP.
REQ-021 STOP drives txd=1 for one tick; on the tick ending STOP, the FSM SHALL load and go to START if hold_full=1, otherwise go to IDLE.
REQ-022 Back-to-back frames SHALL therefore have no idle gap.
REQ-023 txd SHALL be registered; the first start-bit level appears one clk cycle after the first txck_r following capture.
REQ-024 busy SHALL be registered and equal (state != IDLE) | hold_full | (pending capture event).
REQ-025 ovr_clr=1 SHALL clear ovr; if ovr_clr and an overrun occur on the same edge, ovr SHALL be 1.
REQ-026 txpd SHALL be ignored except on capture edges.
REQ-027 Changes on tnpd during a frame SHALL not disturb the frame in progress.

Reset
REQ-028 rst=0 SHALL asynchronously force the following:
- txd=1, busy=0, ovr=0;
- FSM=IDLE, hold_full=0;
- shifter, hold register, bit counter, txck_d and tnpd_d all 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately; no partial frame resumes after release.

Configuration
REQ-030 With TX232_PARITY_EN defined, the frame SHALL be 11 bits: start, 8 data, even parity, stop.
REQ-031 Without TX232_PARITY_EN, the PARITY state and its logic SHALL be absent and the frame SHALL be 10 bits: start, 8 data, stop.

Verification
REQ-032 tnpd rise with txpd=0x35, parity enabled -> txd per tick 0,1,0,1,0,1,1,0,0,0,1, then idle 1; busy falls after stop.
REQ-033 Same stimulus, parity disabled -> txd 0,1,0,1,0,1,1,0,0,1; frame is 10 ticks.
REQ-034 Bytes 0xA5 then 0x0F, second captured mid-frame -> two contiguous frames with no idle tick; ovr=0.
REQ-035 Three captures (0x11, 0x22, 0x33) within one frame -> 0x11 and 0x22 are sent, 0x33 is dropped, ovr=1; ovr_clr pulse -> ovr=0.
REQ-036 rst pulsed at DATA bit 4 of 0xFF -> txd=1 and busy=0 immediately; a following capture of 0x00 sends a clean full frame.
REQ-037 Capture and STOP-end load on the same clk edge -> the queued byte is sent next, the new byte is held, hold_full=1, and ovr=0.

Source files
------------

// File: rtl/tx232_ser_if.sv
// tx232_ser_if: groups the baud clock, the upstream byte handshake and the
// serial-side status outputs of the tx232_ser transmitter.
interface tx232_ser_if;
  logic       txck;
  logic [7:0] txpd;
  logic       tnpd;
  logic       ovr_clr;
  logic       txd;
  logic       busy;
  logic       ovr;

  modport master (
    output txck, txpd, tnpd, ovr_clr,
    input  txd, busy, ovr
  );

  modport slave (
    input  txck, txpd, tnpd, ovr_clr,
    output txd, busy, ovr
  );
endinterface

// File: rtl/tx232_ser.sv
// tx232_ser: single-byte-buffered async serial transmitter.
// Frames are start + 8 data bits (LSB first) + stop; defining the macro
// TX232_PARITY_EN inserts an even parity bit before the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for a held byte
// START  | start bit (0) on the line
// DATA   | data bits 0..7 on the line, bit_cnt selects which
// PARITY | even parity bit on the line (TX232_PARITY_EN only)
// STOP   | stop bit (1) on the line; may chain straight into the next START
module tx232_ser (
  input  logic        clk,
  input  logic        rst,
  tx232_ser_if.slave  bus
);

`ifdef TX232_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t     state_q, state_d;
  logic [1:0] txck_d;
  logic       txck_r;
  logic       tnpd_d;
  logic       cap;
  logic [7:0] hold_q;
  logic       hold_full;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       txd_q, txd_d;
  logic       busy_q;
  logic       ovr_q;
  logic       load;
`ifdef TX232_PARITY_EN
  logic       par_q;
`endif

  assign txck_r   = txck_d[0] & ~txck_d[1];
  assign cap      = bus.tnpd & ~tnpd_d;
  assign bus.txd  = txd_q;
  assign bus.busy = busy_q;
  assign bus.ovr  = ovr_q;

  // Bring the baud clock and the byte strobe into the clk domain for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txck_d <= 2'b00;
      tnpd_d <= 1'b0;
    end else begin
      txck_d <= {txck_d[0], bus.txck};
      tnpd_d <= bus.tnpd;
    end
  end

  // Hold register: a capture coinciding with a load refills hold in the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q    <= 8'h00;
      hold_full <= 1'b0;
    end else if (cap && (!hold_full || load)) begin
      hold_q    <= bus.txpd;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // Sticky overrun; a new overrun wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr_q <= 1'b0;
    end else if (cap && hold_full && !load) begin
      ovr_q <= 1'b1;
    end else if (bus.ovr_clr) begin
      ovr_q <= 1'b0;
    end
  end

  // FSM state, shifter, bit counter and registered line output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
    end
  end

`ifdef TX232_PARITY_EN
  // Parity is taken from the byte as it is loaded, since the shifter is consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q <= 1'b0;
    end else if (load) begin
      par_q <= ^hold_q;
    end
  end
`endif

  // Busy covers an active frame, a held byte and a capture landing this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= (state_q != IDLE) | hold_full | cap;
    end
  end

  // Next-state logic; every move waits for a baud tick.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    txd_d     = txd_q;
    load      = 1'b0;
    if (txck_r) begin
      case (state_q)
        IDLE: begin
          txd_d = 1'b1;
          if (hold_full) begin
            load    = 1'b1;
            shift_d = hold_q;
            txd_d   = 1'b0;
            state_d = START;
          end
        end
        START: begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
          txd_d     = shift_q[0];
        end
        DATA: begin
          if (bit_cnt_q == 3'd7) begin
`ifdef TX232_PARITY_EN
            state_d = PARITY;
            txd_d   = par_q;
`else
            state_d = STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end
`ifdef TX232_PARITY_EN
        PARITY: begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
`endif
        STOP: begin
          if (hold_full) begin
            load    = 1'b1;
            shift_d = hold_q;
            txd_d   = 1'b0;
            state_d = START;
          end else begin
            txd_d   = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          txd_d   = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule
